// File: rtl/div_operand_sequencer_if.sv
// Request and result handshake bundle between div_operand_sequencer and its
// producer/consumer. The sequencer attaches through the slave modport.
interface div_operand_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_numerator;
  logic [WIDTH-1:0] in_denominator;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;

  modport slave (
    input  in_valid,
    input  in_numerator,
    input  in_denominator,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_quotient
  );

  modport master (
    output in_valid,
    output in_numerator,
    output in_denominator,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_quotient
  );
endinterface

// File: rtl/div_operand_sequencer.sv
// Queues divide requests, holds each operand pair on a free-running serial
// divider until its quotient has settled, then hands the quotient downstream.
// Optional macro DIVSEQ_ZERO_BYPASS_EN: zero denominators skip the divider.
module div_operand_sequencer #(
  parameter int WIDTH       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2*WIDTH+3
) (
  input  logic                  clock,
  input  logic                  reset,
  div_operand_sequencer_if.slave bus,
  output logic [WIDTH-1:0]      div_numerator,
  output logic [WIDTH-1:0]      div_denominator,
  input  logic [WIDTH-1:0]      div_quotient,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(HOLD_CYCLES+1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(HOLD_CYCLES-1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [2*WIDTH-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       count_r;
  logic [CNT_W-1:0]     hold_cnt_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_quotient_r;
  logic [WIDTH-1:0]     div_num_r;
  logic [WIDTH-1:0]     div_den_r;

  logic                 empty_s;
  logic                 full_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 load_s;
  logic                 capture_s;
  logic                 bypass_s;
  logic                 release_s;
  logic [2*WIDTH-1:0]   head_s;
  logic [WIDTH-1:0]     head_num_s;
  logic [WIDTH-1:0]     head_den_s;

  assign empty_s    = (count_r == {(PTR_W+1){1'b0}});
  assign full_s     = (count_r == FULL_COUNT);
  // in_ready comes from stored occupancy only, so a same-cycle pop never frees a slot early.
  assign push_s     = bus.in_valid && !full_s;
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign head_num_s = head_s[2*WIDTH-1:WIDTH];
  assign head_den_s = head_s[WIDTH-1:0];

  assign bus.in_ready     = !full_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_quotient = out_quotient_r;
  assign div_numerator    = div_num_r;
  assign div_denominator  = div_den_r;
  assign busy             = (state_r != ST_IDLE) || !empty_s;

  // Next-state and per-cycle action decode for the sequencing FSM.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    capture_s   = 1'b0;
    bypass_s    = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
`ifdef DIVSEQ_ZERO_BYPASS_EN
          if (head_den_s == {WIDTH{1'b0}}) begin
            bypass_s    = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            load_s      = 1'b1;
            state_nxt_s = ST_WAIT;
          end
`else
          load_s      = 1'b1;
          state_nxt_s = ST_WAIT;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // hold_cnt_r counts completed cycles with the current operands visible.
        if (hold_cnt_r == LAST_COUNT) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (out_valid_r && bus.out_ready) begin
          release_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Hold counter: cleared on load, saturates at the capture count.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if (load_s) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_WAIT) && !capture_s) begin
      hold_cnt_r <= hold_cnt_r + CNT_W'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Request FIFO storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {bus.in_numerator, bus.in_denominator};
    end
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Divider operand registers; only a load changes them.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_num_r <= {WIDTH{1'b0}};
      div_den_r <= {WIDTH{1'b0}};
    end else if (load_s) begin
      div_num_r <= head_num_s;
      div_den_r <= head_den_s;
    end else begin
      div_num_r <= div_num_r;
      div_den_r <= div_den_r;
    end
  end

  // Result register and its valid flag toward the consumer.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r    <= 1'b0;
      out_quotient_r <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      out_valid_r    <= 1'b1;
      out_quotient_r <= div_quotient;
    end else if (bypass_s) begin
      out_valid_r    <= 1'b1;
      out_quotient_r <= {WIDTH{1'b1}};
    end else if (release_s) begin
      out_valid_r    <= 1'b0;
      out_quotient_r <= out_quotient_r;
    end else begin
      out_valid_r    <= out_valid_r;
      out_quotient_r <= out_quotient_r;
    end
  end

endmodule
